// File: rtl/module_project_one.sv
// Two-input truth-table cell: per-input synchroniser chains, table lookup, registered output z.
// Defining MODULE_PROJECT_ONE_FILTER_EN adds a stability filter that holds z until a new result persists.
module module_project_one #(
    parameter logic [3:0] TRUTH_TABLE = 4'b0110,
    parameter int         SYNC_STAGES = 2,
    parameter logic       RESET_Z     = 1'b0,
    parameter int         FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic x,
    input  logic y,
    output logic z
);

    if (SYNC_STAGES < 0 || SYNC_STAGES > 4) begin : gBadSyncStages
        $error("module_project_one: SYNC_STAGES must be in 0..4");
    end

    if (FILTER_LEN < 1 || FILTER_LEN > 255) begin : gBadFilterLen
        $error("module_project_one: FILTER_LEN must be in 1..255");
    end

    logic xs;
    logic ys;
    logic r;

    if (SYNC_STAGES == 0) begin : gNoSync
        assign xs = x;
        assign ys = y;
    end else begin : gSync
        logic [SYNC_STAGES-1:0] xSync_q;
        logic [SYNC_STAGES-1:0] ySync_q;

        // Bit 0 captures the raw input; the highest bit feeds the lookup.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                xSync_q <= '0;
                ySync_q <= '0;
            end else begin
                xSync_q[0] <= x;
                ySync_q[0] <= y;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    xSync_q[i] <= xSync_q[i-1];
                    ySync_q[i] <= ySync_q[i-1];
                end
            end
        end

        assign xs = xSync_q[SYNC_STAGES-1];
        assign ys = ySync_q[SYNC_STAGES-1];
    end

    assign r = TRUTH_TABLE[{xs, ys}];

    logic z_q;
    logic z_d;

`ifdef MODULE_PROJECT_ONE_FILTER_EN
    localparam int CntW = (FILTER_LEN < 1) ? 1 : $clog2(FILTER_LEN + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(FILTER_LEN - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    // Any edge where r agrees with z restarts the run of differing edges.
    always_comb begin
        z_d   = z_q;
        cnt_d = cnt_q;
        if (r == z_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            z_d   = r;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            z_q   <= RESET_Z;
            cnt_q <= '0;
        end else begin
            z_q   <= z_d;
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        z_d = r;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            z_q <= RESET_Z;
        end else begin
            z_q <= z_d;
        end
    end
`endif

    assign z = z_q;

endmodule

// File: tb/tb_module_project_one.sv
// Bench for module_project_one: four parameterisations checked every cycle against a delay-line/run-length model,
// plus directed literal checks. Works with or without MODULE_PROJECT_ONE_FILTER_EN defined.
module tb_module_project_one;

`ifdef MODULE_PROJECT_ONE_FILTER_EN
    localparam bit Filt = 1'b1;
`else
    localparam bit Filt = 1'b0;
`endif

    localparam int NumDut = 4;
    localparam logic [3:0] Tt  [NumDut] = '{4'b0110, 4'b1000, 4'b0110, 4'b1110};
    localparam int         Stg [NumDut] = '{2, 0, 0, 3};
    localparam logic       Rz  [NumDut] = '{1'b0, 1'b0, 1'b0, 1'b1};
    localparam int         Fl  [NumDut] = '{4, 1, 4, 2};
    // Edges from an input change on u0 until z shows the new result
    localparam int Lat0 = Filt ? 6 : 3;

    logic clk;
    logic rst_n;
    logic x;
    logic y;
    logic [NumDut-1:0] zDut;

    int checks = 0;
    int passed = 0;

    module_project_one #(.TRUTH_TABLE(Tt[0]), .SYNC_STAGES(Stg[0]), .RESET_Z(Rz[0]), .FILTER_LEN(Fl[0]))
        u0 (.clk(clk), .rst_n(rst_n), .x(x), .y(y), .z(zDut[0]));
    module_project_one #(.TRUTH_TABLE(Tt[1]), .SYNC_STAGES(Stg[1]), .RESET_Z(Rz[1]), .FILTER_LEN(Fl[1]))
        u1 (.clk(clk), .rst_n(rst_n), .x(x), .y(y), .z(zDut[1]));
    module_project_one #(.TRUTH_TABLE(Tt[2]), .SYNC_STAGES(Stg[2]), .RESET_Z(Rz[2]), .FILTER_LEN(Fl[2]))
        u2 (.clk(clk), .rst_n(rst_n), .x(x), .y(y), .z(zDut[2]));
    module_project_one #(.TRUTH_TABLE(Tt[3]), .SYNC_STAGES(Stg[3]), .RESET_Z(Rz[3]), .FILTER_LEN(Fl[3]))
        u3 (.clk(clk), .rst_n(rst_n), .x(x), .y(y), .z(zDut[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: z at edge e is the table applied to {x,y} sampled Stg edges earlier,
    // and with the filter z only flips once that result has disagreed for Fl consecutive edges.
    logic [1:0] hist [NumDut][5];
    logic       zModel [NumDut];
    int         run [NumDut];
    bit         modelValid = 1'b0;

    always @(posedge clk) begin
        logic [1:0] idx;
        logic       rv;
        for (int k = 0; k < NumDut; k++) begin
            if (!rst_n) begin
                for (int i = 0; i < 5; i++) hist[k][i] = 2'b00;
                zModel[k] = Rz[k];
                run[k] = 0;
            end else begin
                idx = (Stg[k] == 0) ? {x, y} : hist[k][Stg[k]-1];
                for (int i = 4; i > 0; i--) hist[k][i] = hist[k][i-1];
                hist[k][0] = {x, y};
                rv = Tt[k][idx];
                if (!Filt) begin
                    zModel[k] = rv;
                end else if (rv == zModel[k]) begin
                    run[k] = 0;
                end else begin
                    run[k]++;
                    if (run[k] == Fl[k]) begin
                        zModel[k] = rv;
                        run[k] = 0;
                    end
                end
            end
        end
        if (!rst_n) modelValid = 1'b1;
    end

    task automatic checkOutput(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %b, required %b", name, act, exp);
    endtask

    // Cycle-by-cycle comparison of every instance against the model
    always @(negedge clk) begin
        if (modelValid) begin
            for (int k = 0; k < NumDut; k++) begin
                checkOutput($sformatf("model_u%0d t=%0t", k, $time), zDut[k], zModel[k]);
            end
        end
    end

    task automatic applyStimulus(input logic xv, input logic yv, input logic rv);
        @(negedge clk);
        x = xv;
        y = yv;
        rst_n = rv;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [1:0] sweepIn  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic       sweepExp [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        x = 1'b1;
        y = 1'b0;
        rst_n = 1'b0;

        // Reset held with inputs active
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(3);
        checkOutput("reset_u0", zDut[0], 1'b0);
        checkOutput("reset_u3", zDut[3], 1'b1);

        applyStimulus(1'b0, 1'b0, 1'b1);
        tick(4);
        checkOutput("release_u0", zDut[0], 1'b0);

        // Truth table sweep on the default instance
        for (int i = 0; i < 4; i++) begin
            applyStimulus(sweepIn[i][1], sweepIn[i][0], 1'b1);
            tick(Lat0 - 1);
            checkOutput($sformatf("sweep_before_%0d", i), zDut[0], (i == 0) ? 1'b0 : sweepExp[i-1]);
            tick(1);
            checkOutput($sformatf("sweep_after_%0d", i), zDut[0], sweepExp[i]);
            tick(10 - Lat0);
        end

        // AND table, no synchroniser, FILTER_LEN=1
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick(1);
        checkOutput("and_00", zDut[1], 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick(1);
        checkOutput("and_11", zDut[1], 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick(1);
        checkOutput("and_10", zDut[1], 1'b0);

        // Mid-operation reset with z=1
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick(8);
        checkOutput("midrst_pre", zDut[0], 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick(1);
        checkOutput("midrst_at", zDut[0], 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick(Lat0 - 1);
        checkOutput("midrst_wait", zDut[0], 1'b0);
        tick(1);
        checkOutput("midrst_back", zDut[0], 1'b1);

        // Filter run-length behaviour on u2 (XOR, no synchroniser)
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick(8);
        checkOutput("filt_base", zDut[2], 1'b0);
`ifdef MODULE_PROJECT_ONE_FILTER_EN
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick(3);
        checkOutput("filt_short", zDut[2], 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick(2);
        checkOutput("filt_short_back", zDut[2], 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick(3);
        checkOutput("filt_hold3", zDut[2], 1'b0);
        tick(1);
        checkOutput("filt_hold4", zDut[2], 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick(4);
        checkOutput("filt_fall", zDut[2], 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick(2);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick(1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick(3);
        checkOutput("filt_restart3", zDut[2], 1'b0);
        tick(1);
        checkOutput("filt_restart4", zDut[2], 1'b1);
`else
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick(1);
        checkOutput("nofilt_01", zDut[2], 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick(1);
        checkOutput("nofilt_00", zDut[2], 1'b0);
`endif

        // Randomised phase: mostly slow inputs with bursts of fast toggling and rare resets
        for (int c = 0; c < 3000; c++) begin
            logic rstv;
            rstv = ($urandom_range(0, 59) != 0);
            if ((c / 200) % 2 == 0) begin
                if ($urandom_range(0, 5) == 0)
                    applyStimulus(1'($urandom), 1'($urandom), rstv);
                else
                    applyStimulus(x, y, rstv);
            end else begin
                applyStimulus(1'($urandom), 1'($urandom), rstv);
            end
        end

        tick(2);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
